// File: rtl/weight_row_reader_if.sv
// Valid/ready beat stream carrying one ternary weight, its offset within the
// row and a last-of-row flag. The reader drives it through the master modport.
interface weight_row_reader_if #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 10
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_index;
  logic                  out_last;

  modport master (
    output out_valid, out_data, out_index, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_index, out_last,
    output out_ready
  );
endinterface

// File: rtl/weight_row_reader.sv
// Streaming row reader for the ternary weight RAM. Walks a wrap-around address
// range on the combinational read port and delivers each weight through a
// 2-entry buffer so that a stalled consumer never loses a beat while full
// throughput is kept when the consumer is always ready.
module weight_row_reader #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_NEURON = 1024
) (
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] aout,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy,
  output logic                  done,
  weight_row_reader_if.master   out_bus
);

  // One extra bit so a full-depth row length and base+offset both fit.
  typedef logic [ADDR_WIDTH:0] wide_t;
  localparam wide_t NUM_W = wide_t'(NUM_NEURON);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] base_q;
  wide_t                 len_q;
  wide_t                 offset_q;
  wide_t                 len_clamped;
  wide_t                 addr_raw;
  wide_t                 addr_wrap;

  logic [DATA_WIDTH-1:0] buf_data  [2];
  logic [ADDR_WIDTH-1:0] buf_index [2];
  logic                  buf_last  [2];
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            count_q;

  logic pop;
  logic push;
  logic issue_last;
  logic start_row;

  // Handshake, read-issue and address arithmetic; a pop in the same cycle
  // frees a slot so a full buffer can still accept a read when draining.
  always_comb begin
    len_clamped = (length > NUM_W) ? NUM_W : length;
    addr_raw    = wide_t'(base_q) + offset_q;
    addr_wrap   = (addr_raw >= NUM_W) ? (addr_raw - NUM_W) : addr_raw;
    pop         = (count_q != 2'd0) && out_bus.out_ready;
    push        = (state_q == READ) && ((count_q != 2'd2) || pop);
    issue_last  = (offset_q == (len_q - wide_t'(1)));
    aout        = push ? addr_wrap[ADDR_WIDTH-1:0] : '0;
  end

  // Next-state logic; DRAIN leaves as soon as the buffer will be empty so
  // done lands in the cycle right after the final beat is accepted.
  always_comb begin
    state_d   = state_q;
    start_row = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_row = 1'b1;
          state_d   = (len_clamped == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (push && issue_last) state_d = DRAIN;
      end
      DRAIN: begin
        if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs and the head of the buffer presented downstream.
  always_comb begin
    busy              = (state_q == READ) || (state_q == DRAIN);
    done              = (state_q == DONE);
    out_bus.out_valid = (count_q != 2'd0);
    out_bus.out_data  = buf_data[rd_ptr_q];
    out_bus.out_index = buf_index[rd_ptr_q];
    out_bus.out_last  = buf_last[rd_ptr_q];
  end

  // State register.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Row parameters latched at start and the running read offset.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      base_q   <= '0;
      len_q    <= '0;
      offset_q <= '0;
    end else if (start_row) begin
      base_q   <= base_addr;
      len_q    <= len_clamped;
      offset_q <= '0;
    end else if (push) begin
      offset_q <= offset_q + wide_t'(1);
    end
  end

  // Two-entry output buffer; entries are tagged with their row offset.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < 2; i++) begin
        buf_data[i]  <= '0;
        buf_index[i] <= '0;
        buf_last[i]  <= 1'b0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        buf_data[wr_ptr_q]  <= ram_dout;
        buf_index[wr_ptr_q] <= offset_q[ADDR_WIDTH-1:0];
        buf_last[wr_ptr_q]  <= issue_last;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
